// File: rtl/input_skew_feeder.sv
// Diagonal skew feeder for the west edge of the PE array: row i delays
// element i by i+1 cycles, then drains the diagonal after the last vector.

module isf_row #(
  parameter int DEPTH = 1,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o
);
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [DEPTH-1:0]         vld_q;

  // A cycle without a load injects a zero bubble, so the skew stays aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      vld_q  <= '0;
    end else begin
      data_q[0] <= ld_i ? data_i : '0;
      vld_q[0]  <= ld_i;
      for (int k = 1; k < DEPTH; k++) begin
        data_q[k] <= data_q[k-1];
        vld_q[k]  <= vld_q[k-1];
      end
    end
  end

  assign data_o  = data_q[DEPTH-1];
  assign valid_o = vld_q[DEPTH-1];
endmodule

module input_skew_feeder #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  input  logic            in_last,
  output logic [N*DW-1:0] out_data,
  output logic [N-1:0]    out_valid,
  output logic            c_en,
  output logic            busy,
  output logic            done
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   last_q;
  logic           accept;

  assign in_ready = (state_q != DRAIN);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != IDLE);
  assign c_en     = |out_valid;
  assign done     = last_q[N-1];

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_row
      isf_row #(.DEPTH(i + 1), .DW(DW)) u_row (
        .clk     (clk),
        .reset   (reset),
        .ld_i    (accept),
        .data_i  (in_data[i*DW +: DW]),
        .data_o  (out_data[i*DW +: DW]),
        .valid_o (out_valid[i])
      );
    end
  endgenerate

  // Tile-end marker travels alongside row N-1 so done lines up with its last element.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q  <= '0;
      state_q <= IDLE;
    end else begin
      last_q[0] <= accept && in_last;
      for (int k = 1; k < N; k++) last_q[k] <= last_q[k-1];
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_last ? DRAIN : STREAM;
      STREAM:  if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_input_skew_feeder.sv
// Directed bench for input_skew_feeder with N=4, DW=32.
module tb_input_skew_feeder;
  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 0;
  logic            reset;
  logic            in_valid, in_last;
  logic [N*DW-1:0] in_data;
  logic            in_ready, c_en, busy, done;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]    out_valid;

  int n_chk = 0;
  int n_err = 0;

  input_skew_feeder #(.N(N), .DW(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_data(out_data),
    .out_valid(out_valid), .c_en(c_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            vld, lst;
    logic [N*DW-1:0] din;
    logic [N-1:0]    ov;
    logic [N*DW-1:0] dout;
    logic            dn, rdy, bsy, cen;
  } vec_t;

  vec_t tbl[24];

  function automatic logic [N*DW-1:0] pk(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic vec_t mk(input logic v, l, input logic [N*DW-1:0] di,
                              input logic [N-1:0] ov, input logic [N*DW-1:0] dout,
                              input logic dn, rdy, bsy);
    vec_t r;
    r.vld = v; r.lst = l; r.din = di; r.ov = ov; r.dout = dout;
    r.dn = dn; r.rdy = rdy; r.bsy = bsy; r.cen = |ov;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [N*DW-1:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input logic v, l, input logic [N*DW-1:0] d);
    in_valid = v; in_last = l; in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [N-1:0] ov,
                         input logic [N*DW-1:0] dout, input logic dn, rdy, bsy, cen);
    chk({tag, ".out_valid"}, N*DW'(out_valid), N*DW'(ov));
    chk({tag, ".out_data"},  out_data, dout);
    chk({tag, ".done"},      N*DW'(done), N*DW'(dn));
    chk({tag, ".in_ready"},  N*DW'(in_ready), N*DW'(rdy));
    chk({tag, ".busy"},      N*DW'(busy), N*DW'(bsy));
    chk({tag, ".c_en"},      N*DW'(c_en), N*DW'(cen));
  endtask

  initial begin
    logic [N*DW-1:0] z, vb;
    z = '0;
    // single vector with last
    tbl[0]  = mk(1, 1, pk(1,2,3,4),     4'b0001, pk(1,0,0,0),  0, 0, 1);
    tbl[1]  = mk(0, 0, z,               4'b0010, pk(0,2,0,0),  0, 0, 1);
    tbl[2]  = mk(0, 0, z,               4'b0100, pk(0,0,3,0),  0, 0, 1);
    tbl[3]  = mk(0, 0, z,               4'b1000, pk(0,0,0,4),  1, 0, 1);
    tbl[4]  = mk(0, 0, z,               4'b0000, z,            0, 1, 0);
    // three back-to-back vectors
    tbl[5]  = mk(1, 0, pk(10,11,12,13), 4'b0001, pk(10,0,0,0),  0, 1, 1);
    tbl[6]  = mk(1, 0, pk(20,21,22,23), 4'b0011, pk(20,11,0,0), 0, 1, 1);
    tbl[7]  = mk(1, 1, pk(30,31,32,33), 4'b0111, pk(30,21,12,0),0, 0, 1);
    tbl[8]  = mk(0, 0, z,               4'b1110, pk(0,31,22,13),0, 0, 1);
    tbl[9]  = mk(0, 0, z,               4'b1100, pk(0,0,32,23), 0, 0, 1);
    tbl[10] = mk(0, 0, z,               4'b1000, pk(0,0,0,33),  1, 0, 1);
    tbl[11] = mk(0, 0, z,               4'b0000, z,             0, 1, 0);
    // bubble between two vectors
    tbl[12] = mk(1, 0, pk(1,2,3,4),     4'b0001, pk(1,0,0,0),  0, 1, 1);
    tbl[13] = mk(0, 1, pk(7,7,7,7),     4'b0010, pk(0,2,0,0),  0, 1, 1);
    tbl[14] = mk(1, 1, pk(5,6,7,8),     4'b0101, pk(5,0,3,0),  0, 0, 1);
    tbl[15] = mk(0, 0, z,               4'b1010, pk(0,6,0,4),  0, 0, 1);
    tbl[16] = mk(0, 0, z,               4'b0100, pk(0,0,7,0),  0, 0, 1);
    tbl[17] = mk(0, 0, z,               4'b1000, pk(0,0,0,8),  1, 0, 1);
    tbl[18] = mk(0, 0, z,               4'b0000, z,            0, 1, 0);
    // signed extremes
    tbl[19] = mk(1, 1, pk(32'h80000000,32'h7FFFFFFF,32'hFFFFFFFF,0), 4'b0001, pk(32'h80000000,0,0,0), 0, 0, 1);
    tbl[20] = mk(0, 0, z, 4'b0010, pk(0,32'h7FFFFFFF,0,0), 0, 0, 1);
    tbl[21] = mk(0, 0, z, 4'b0100, pk(0,0,32'hFFFFFFFF,0), 0, 0, 1);
    tbl[22] = mk(0, 0, z, 4'b1000, z,                      1, 0, 1);
    tbl[23] = mk(0, 0, z, 4'b0000, z,                      0, 1, 0);

    reset = 1; in_valid = 0; in_last = 0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 4'b0000, z, 0, 1, 0, 0);
    reset = 0;

    for (int k = 0; k < 24; k++) begin
      step(tbl[k].vld, tbl[k].lst, tbl[k].din);
      chk_all($sformatf("vec%0d", k), tbl[k].ov, tbl[k].dout,
              tbl[k].dn, tbl[k].rdy, tbl[k].bsy, tbl[k].cen);
    end

    // valid held through DRAIN: not consumed until IDLE returns
    vb = pk(9,10,11,12);
    step(1, 1, pk(1,2,3,4));
    for (int k = 1; k <= 3; k++) begin
      step(1, 1, vb);
      chk($sformatf("hold%0d.in_ready", k), N*DW'(in_ready), '0);
      chk($sformatf("hold%0d.row0_valid", k), N*DW'(out_valid[0]), '0);
    end
    chk("hold.done_c4", N*DW'(done), N*DW'(1));
    step(1, 1, vb);
    chk_all("hold.idle", 4'b0000, z, 0, 1, 0, 0);
    step(1, 1, vb);
    chk_all("hold.accept", 4'b0001, pk(9,0,0,0), 0, 0, 1, 1);
    step(0, 0, z);
    step(0, 0, z);
    step(0, 0, z);
    chk_all("hold.done", 4'b1000, pk(0,0,0,12), 1, 0, 1, 1);
    step(0, 0, z);
    chk_all("hold.end", 4'b0000, z, 0, 1, 0, 0);

    // reset mid-tile discards everything
    step(1, 0, pk(10,11,12,13));
    step(1, 0, pk(20,21,22,23));
    reset = 1;
    step(1, 1, pk(30,31,32,33));
    chk_all("midrst", 4'b0000, z, 0, 1, 0, 0);
    reset = 0;
    for (int k = 0; k < 6; k++) begin
      step(0, 0, z);
      chk($sformatf("postrst%0d.done", k), N*DW'(done), '0);
      chk($sformatf("postrst%0d.out_valid", k), N*DW'(out_valid), '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/input_skew_feeder.md
# input_skew_feeder

Feeds activation vectors from the input buffer into the west edge of the PE array, applying diagonal (systolic) skew so that row i of the array sees element i of a vector i cycles after row 0. It sits directly upstream of the PE rows' `in_input` ports. It accepts one N-element vector per cycle over a valid/ready handshake, then drains the skew pipeline after the last vector of a tile. It generates per-row valid, compute-enable and a tile-done pulse.

## Interface
Parameters:
- `N`, 4, number of PE rows (≥1)
- `DW`, 32, element width (signed two's complement)

Ports:
- `clk`  in  1  single clock; all logic rising-edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream vector valid
- `in_ready`  out  1  feeder can accept a vector this cycle
- `in_data`  in  N*DW  vector; element i at `[i*DW +: DW]`
- `in_last`  in  1  marks final vector of a tile (sampled with handshake)
- `out_data`  out  N*DW  skewed data; row i at `[i*DW +: DW]`, drives PE row i `in_input`
- `out_valid`  out  N  row i element valid
- `c_en`  out  1  OR of `out_valid`; compute enable to the array
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse: last element of tile present on row N-1

## Operation
- Accept = `in_valid && in_ready`.
- Row i is a chain of i+1 registers (data + valid). Row N-1 also carries a `last` bit. All chains shift every cycle; there is no downstream backpressure.
- Stage 0 of every row loads `in_data` element i with valid=1 on accept. Otherwise it loads 0 with valid=0, inserting a bubble. Bubbles keep skew alignment intact.
- Data passes unmodified; no arithmetic, no width change.
- FSM states:
  - IDLE: `in_ready`=1. Accept with `in_last`=0 goes to STREAM. Accept with `in_last`=1 goes to DRAIN.
  - STREAM: `in_ready`=1. Accept with `in_last`=1 goes to DRAIN. A cycle with no accept is a bubble, and the FSM stays in STREAM.
  - DRAIN: `in_ready`=0. Zero/invalid is injected each cycle. Go to IDLE in the cycle `done` is high.
- `in_last` is ignored when there is no accept.
- `done` = `last` bit at the output register of row N-1. It is high for exactly one cycle per tile.
- `c_en` and `busy` are combinational from registered state.
- Reset (any state, including mid-tile): FSM goes to IDLE and every data, valid and last register is cleared. In-flight elements are discarded and no `done` is produced for the aborted tile.
- N=1: row 0 has a single stage. DRAIN lasts exactly one cycle.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `c_en`=0, `busy`=0, `done`=0, `in_ready`=1 (IDLE).
- Vector accepted at edge t: row i element is on `out_data`/`out_valid[i]` during cycle t+1+i. Latency is 1 cycle for row 0 and N cycles for row N-1.
- Last vector accepted at edge t:
  - state is DRAIN from t+1;
  - `done`=1 during cycle t+N;
  - state is IDLE and `in_ready`=1 in cycle t+N+1.
- DRAIN length is therefore N cycles. Upstream sees `in_ready` low for exactly N cycles after the last beat.
- Back-to-back accepts give a full-rate diagonal wavefront. `out_valid` for a tile of K gap-free vectors spans cycles t0+1 … t0+K+N-1, where t0 is the edge of the first accept.
- Throughput is one vector per cycle outside DRAIN.

## Test plan
1. Reset, then N=4 single vector {1,2,3,4} with `in_last`=1 at edge 0 → row0=1 in cycle 1, row1=2 in cycle 2, row2=3 in cycle 3, row3=4 in cycle 4. `done` high in cycle 4, `in_ready` low in cycles 1–4 and high in cycle 5.
2. Three back-to-back vectors {10,11,12,13}, {20,…}, {30,…} with last on the third → each row shows 3 consecutive valid elements starting at cycle 1+i. `c_en` is high cycles 1–6 and `done` fires once in cycle 6.
3. Bubble insertion: accept at edges 0 and 2 with `in_valid`=0 at edge 1 → every row shows valid, invalid (data 0), valid, offset by i. The FSM stays in STREAM during the gap.
4. `in_valid` held high during DRAIN → no accept, data not consumed. The held vector is accepted in the first IDLE cycle after `done`.
5. Reset asserted mid-tile (cycle 2 of scenario 2) → next cycle all `out_valid`=0, `out_data`=0, `busy`=0, `in_ready`=1. No `done` follows.
6. Signed extremes: vector {0x80000000, 0x7FFFFFFF, −1, 0} → values emerge bit-exact on rows 0–3 with correct skew.
